// File: rtl/coef_ram_pkg.sv
// Shared definitions for the coefficient RAM loader: default coefficient
// width, address width, table depth and the loader FSM state encoding.
package coef_ram_pkg;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/coef_ram_loader_if.sv
// Write-stream interface for the coefficient loader: a valid/ready beat
// carrying one coefficient. The producer uses the master modport and the
// loader uses the slave modport.
interface coef_ram_loader_if #(
    parameter int DW = coef_ram_pkg::DW
) ();
    import coef_ram_pkg::*;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/coef_dp_ram.sv
// Simple dual-port coefficient store: one write port and two read ports,
// both reads registered with one cycle of latency. Reads return the old
// word when the same address is written on the same edge. The storage
// array itself is never reset; only the read output registers are.
module coef_dp_ram
    import coef_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata1_reg;
    logic [DATA_W-1:0] rdata2_reg;

    // Write port: storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: sample every cycle, read-before-write on address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata1_reg <= '0;
            rdata2_reg <= '0;
        end else begin
            rdata1_reg <= mem[raddr1];
            rdata2_reg <= mem[raddr2];
        end
    end

    assign rdata1 = rdata1_reg;
    assign rdata2 = rdata2_reg;

endmodule

// File: rtl/coef_ram_loader.sv
// Coefficient RAM loader: on start, accepts exactly 2**AW beats from a
// valid/ready stream and writes them into a dual-read-port table, then
// holds done until the next start. Both read ports run continuously.
// Optional build macro COEF_LOADER_BITREV_EN: beat k is written to the
// bit-reversed address of k instead of address k.
module coef_ram_loader #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    coef_ram_loader_if.slave     wr,
    input  logic [AW-1:0]        address1,
    input  logic [AW-1:0]        address2,
    output logic [DW-1:0]        a,
    output logic [DW-1:0]        b,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          count
);
    import coef_ram_pkg::*;

    localparam int          NWORDS   = 2 ** AW;
    localparam logic [AW:0] LAST_CNT = (AW+1)'(NWORDS - 1);

    loader_state_t state_reg;
    logic [AW-1:0] wptr_reg;
    logic [AW:0]   count_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          ready_reg;

    logic          accept;
    logic          we;
    logic [AW-1:0] waddr;

    // ready_reg is only ever high in LOAD, so this is the beat handshake.
    assign accept = wr.in_valid & ready_reg;
    // No write on a reset edge, even if a beat was being offered.
    assign we     = accept & rst_n;

`ifdef COEF_LOADER_BITREV_EN
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
            assign waddr[gi] = wptr_reg[AW-1-gi];
        end
    endgenerate
`else
    assign waddr = wptr_reg;
`endif

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            wptr_reg  <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= LOAD;
                        wptr_reg  <= '0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wptr_reg  <= wptr_reg + AW'(1);
                        count_reg <= count_reg + (AW+1)'(1);
                        if (count_reg == LAST_CNT) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    coef_dp_ram #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wr.in_data),
        .raddr1 (address1),
        .raddr2 (address2),
        .rdata1 (a),
        .rdata2 (b)
    );

    assign wr.in_ready = ready_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign count       = count_reg;

endmodule

// File: tb/tb_coef_ram_loader.sv
// Self-checking bench for coef_ram_loader. A reference memory model feeds a
// scoreboard: each cycle the expected read-port values are pushed before the
// clock edge and popped and compared just after it.
module tb_coef_ram_loader;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] address1;
    logic [AW-1:0] address2;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    coef_ram_loader_if #(.DW(DW)) wr_if ();

    coef_ram_loader #(
        .DW (DW),
        .AW (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr       (wr_if),
        .address1 (address1),
        .address2 (address2),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    int model_mem [DEPTH];
    bit known     [DEPTH];
    int exp_a_q [$];
    int exp_b_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int k);
        logic [AW-1:0] kk;
        logic [AW-1:0] r;
        kk = k[AW-1:0];
`ifdef COEF_LOADER_BITREV_EN
        for (int i = 0; i < AW; i++) r[i] = kk[AW-1-i];
`else
        r = kk;
`endif
        return int'(r);
    endfunction

    // One clock: queue expected read data (memory before this edge's write),
    // apply the write to the model, clock, then compare.
    task automatic cycle(input bit wr_en, input int k, input int data);
        int ea;
        int eb;
        if (!rst_n) begin
            ea = 0;
            eb = 0;
        end else begin
            ea = known[address1] ? model_mem[address1] : -1;
            eb = known[address2] ? model_mem[address2] : -1;
        end
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        if (wr_en && rst_n) begin
            model_mem[addr_of(k)] = data;
            known[addr_of(k)]     = 1'b1;
        end
        @(posedge clk);
        #1;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        if (ea >= 0) check_val("rd_a", int'(a), ea);
        if (eb >= 0) check_val("rd_b", int'(b), eb);
    endtask

    task automatic check_status(input string tag, input int e_busy, input int e_done,
                                input int e_ready, input int e_count);
        check_val({tag, "_busy"},  int'(busy),           e_busy);
        check_val({tag, "_done"},  int'(done),           e_done);
        check_val({tag, "_ready"}, int'(wr_if.in_ready), e_ready);
        check_val({tag, "_count"}, int'(count),          e_count);
    endtask

    task automatic do_reset(input int n);
        rst_n          = 1'b0;
        start          = 1'b0;
        wr_if.in_valid = 1'b1;
        wr_if.in_data  = 16'hBEEF;
        repeat (n) cycle(1'b0, 0, 0);
        rst_n          = 1'b1;
        wr_if.in_valid = 1'b0;
        check_status("reset", 0, 0, 0, 0);
    endtask

    task automatic pulse_start();
        start          = 1'b1;
        wr_if.in_valid = 1'b0;
        cycle(1'b0, 0, 0);
        start          = 1'b0;
        check_status("start", 1, 0, 1, 0);
    endtask

    // Drive nbeats beats of base+k; gappy offers a beat every other cycle
    // and also pulses start mid-load, which must be ignored.
    task automatic load(input int nbeats, input int base, input bit gappy);
        int k;
        int cyc;
        bit v;
        k   = 0;
        cyc = 0;
        while (k < nbeats && cyc < 4 * DEPTH) begin
            v              = gappy ? (cyc % 2 == 1) : 1'b1;
            wr_if.in_valid = v;
            wr_if.in_data  = DW'(base + k);
            start          = gappy && (k == 100) && !v;
            cycle(v, k, base + k);
            start = 1'b0;
            if (v) k++;
            check_status("load", (k < DEPTH) ? 1 : 0, (k == DEPTH) ? 1 : 0,
                         (k < DEPTH) ? 1 : 0, k);
            cyc++;
        end
        wr_if.in_valid = 1'b0;
        if (k < nbeats) check_val("load_timeout", k, nbeats);
    endtask

    task automatic sweep_reads();
        for (int i = 0; i < DEPTH; i++) begin
            address1 = AW'(i);
            address2 = AW'(DEPTH - 1 - i);
            cycle(1'b0, 0, 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        wr_if.in_valid = 1'b0;
        wr_if.in_data  = '0;
        address1       = AW'(5);
        address2       = AW'(7);

        do_reset(3);

        // Back-to-back load of k+100, then extra beats offered in DONE.
        pulse_start();
        load(DEPTH, 100, 1'b0);
        wr_if.in_valid = 1'b1;
        wr_if.in_data  = 16'hDEAD;
        repeat (3) begin
            cycle(1'b0, 0, 0);
            check_status("done_hold", 0, 1, 0, DEPTH);
        end
        wr_if.in_valid = 1'b0;
        address1 = AW'(5);
        cycle(1'b0, 0, 0);
`ifndef COEF_LOADER_BITREV_EN
        check_val("a_addr5", int'(a), 105);
`endif

        // Reset keeps memory; beats offered in IDLE are ignored.
        do_reset(2);
        wr_if.in_valid = 1'b1;
        wr_if.in_data  = 16'hDEAD;
        repeat (4) begin
            cycle(1'b0, 0, 0);
            check_status("idle", 0, 0, 0, 0);
        end
        wr_if.in_valid = 1'b0;
        sweep_reads();

        // Load with valid gaps.
        pulse_start();
        load(DEPTH, 1000, 1'b1);
        sweep_reads();

        // Abort after 10 beats, then a full reload watching a word being rewritten.
        pulse_start();
        load(10, 2000, 1'b0);
        do_reset(2);
        address1 = AW'(addr_of(7));
        address2 = AW'(addr_of(7));
        pulse_start();
        load(DEPTH, 0, 1'b0);
        sweep_reads();

`ifdef COEF_LOADER_BITREV_EN
        address1 = AW'(128);
        address2 = AW'(192);
        cycle(1'b0, 0, 0);
        check_val("bitrev_128", int'(a), 1);
        check_val("bitrev_192", int'(b), 3);
`else
        address1 = AW'(5);
        address2 = AW'(5);
        cycle(1'b0, 0, 0);
        check_val("same_addr_a", int'(a), 5);
        check_val("same_addr_b", int'(b), 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
